// File: rtl/cpu_host_ctrl.sv
// Host-to-CPU bridge: streams image bytes into CPU memory, runs the CPU, then reads results back.
// Load accepts one byte/cycle via valid/ready; readback yields one byte per RD_LAT+2 cycles, held under out_ready=0.
module cpu_host_ctrl #(
    parameter int IN_COUNT  = 65536,
    parameter int OUT_COUNT = 16129,
    parameter int RD_LAT    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic [1:0]  cpu_status,
    output logic [15:0] cpu_addr,
    output logic [7:0]  cpu_data,
    input  logic        cpu_end,
    input  logic [7:0]  cpu_out,
    output logic        busy,
    output logic        done
);
    typedef enum logic [2:0] {
        IDLE, LOAD, PROC, RD_ISSUE, RD_WAIT, RD_OUT, DONE
    } state_t;

    localparam logic [1:0]  ST_IDLE   = 2'b00;
    localparam logic [1:0]  ST_LOAD   = 2'b10;
    localparam logic [1:0]  ST_PROC   = 2'b01;
    localparam logic [1:0]  ST_READ   = 2'b11;
    localparam logic [16:0] LOAD_LAST = 17'(IN_COUNT - 1);
    localparam logic [15:0] RD_LAST   = 16'(OUT_COUNT - 1);
    localparam logic [3:0]  LAT       = 4'(RD_LAT);

    state_t      state;
    logic [16:0] load_count;
    logic [15:0] rd_count;
    logic [3:0]  wait_count;
    logic        proc_first;
    logic        in_hs;

    assign in_hs = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            load_count <= '0;
            rd_count   <= '0;
            wait_count <= '0;
            proc_first <= 1'b0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            cpu_status <= ST_IDLE;
            cpu_addr   <= '0;
            cpu_data   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, LOAD: begin
                    if (in_hs) begin
                        cpu_status <= ST_LOAD;
                        cpu_addr   <= load_count[15:0];
                        cpu_data   <= in_data;
                        load_count <= load_count + 17'd1;
                        busy       <= 1'b1;
                        // The final write is still presented to the CPU during the first PROC cycle.
                        if (load_count == LOAD_LAST) begin
                            state      <= PROC;
                            in_ready   <= 1'b0;
                            proc_first <= 1'b1;
                        end else begin
                            state <= LOAD;
                        end
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                PROC: begin
                    cpu_status <= ST_PROC;
                    proc_first <= 1'b0;
                    // A stale cpu_end from a previous run must not end processing immediately.
                    if (!proc_first && cpu_end) begin
                        state    <= RD_ISSUE;
                        rd_count <= '0;
                    end
                end
                RD_ISSUE: begin
                    cpu_status <= ST_READ;
                    cpu_addr   <= rd_count;
                    wait_count <= 4'd1;
                    state      <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (wait_count >= LAT) begin
                        out_data  <= cpu_out;
                        out_valid <= 1'b1;
                        state     <= RD_OUT;
                    end else begin
                        wait_count <= wait_count + 4'd1;
                    end
                end
                RD_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (rd_count == RD_LAST) begin
                            state      <= DONE;
                            done       <= 1'b1;
                            cpu_status <= ST_IDLE;
                        end else begin
                            rd_count <= rd_count + 16'd1;
                            state    <= RD_ISSUE;
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    in_ready   <= 1'b1;
                    load_count <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_host_ctrl.sv
// Directed bench for cpu_host_ctrl with reduced image/result sizes and a one-register CPU memory model.
module tb_cpu_host_ctrl;
    localparam int IN_N  = 600;
    localparam int OUT_N = 260;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready = 1'b0;
    logic [1:0]  cpu_status;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_end = 1'b0;
    logic [7:0]  cpu_out;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Memory returns addr[7:0] one edge after the address appears, ready for the RD_LAT=2 sample edge.
    logic [7:0] mem_q = 8'h00;
    assign cpu_out = mem_q;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        mem_q <= cpu_addr[7:0];
    end

    cpu_host_ctrl #(.IN_COUNT(IN_N), .OUT_COUNT(OUT_N), .RD_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .cpu_status(cpu_status), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_end(cpu_end), .cpu_out(cpu_out),
        .busy(busy), .done(done)
    );

    typedef struct packed {
        logic        vld;
        logic [7:0]  dat;
        logic [1:0]  st;
        logic [15:0] addr;
        logic [7:0]  wd;
        logic        rdy;
        logic        bsy;
    } vec_t;

    vec_t vecs[6];

    int          ld_cnt;
    logic        m_rdy;
    logic [1:0]  m_st;
    logic [15:0] m_addr;
    logic [7:0]  m_dat;
    bit          seen[IN_N];
    int          n_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_status"}, cpu_status, 2'b00);
        check({name, "_addr"}, cpu_addr, 16'h0000);
        check({name, "_data"}, cpu_data, 8'h00);
        check({name, "_out"}, {out_data, out_valid}, 9'h000);
        check({name, "_flags"}, {in_ready, busy, done}, 3'b000);
    endtask

    task automatic run_load(input bit bubbly, input int stop_at);
        int guard = 0;
        bit hs;
        bit tog = 1'b0;
        int idx;
        while (ld_cnt < stop_at && guard < 4 * IN_N) begin
            guard++;
            tog      = !tog;
            in_valid = bubbly ? tog : 1'b1;
            in_data  = 8'(ld_cnt);
            hs       = in_valid && m_rdy;
            @(negedge clk);
            if (hs) begin
                m_st   = 2'b10;
                m_addr = 16'(ld_cnt);
                m_dat  = 8'(ld_cnt);
                ld_cnt++;
                m_rdy  = (ld_cnt < IN_N);
            end else if (ld_cnt < IN_N) begin
                m_rdy = 1'b1;
            end
            check("load", {cpu_status, cpu_addr, cpu_data, in_ready}, {m_st, m_addr, m_dat, m_rdy});
            idx = int'(cpu_addr);
            if (hs && cpu_status == 2'b10 && idx < IN_N) begin
                if (!seen[idx]) n_seen++;
                seen[idx] = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (ld_cnt < stop_at) check("load_timeout", ld_cnt, stop_at);
    endtask

    task automatic run_read(input bit bp);
        int n;
        int last = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < OUT_N; i++) begin
            n = 0;
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!out_valid) begin
                check("read_timeout", i, OUT_N);
                return;
            end
            check("rd_byte", {out_data, cpu_addr, cpu_status, done}, {8'(i), 16'(i), 2'b11, 1'b0});
            if (i > 0 && !(bp && i == 101)) check("rd_gap", cyc - last, LAT + 2);
            last = cyc;
            if (bp && i == 100) begin
                out_ready = 1'b0;
                repeat (10) begin
                    @(negedge clk);
                    check("bp_hold", {out_valid, out_data, cpu_addr}, {1'b1, 8'd100, 16'd100});
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        check("done_pulse", {done, out_valid, cpu_status, busy}, {1'b1, 1'b0, 2'b00, 1'b1});
        @(negedge clk);
        check("back_idle", {done, busy, in_ready}, {1'b0, 1'b0, 1'b1});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t reached, expected finish earlier", $time);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 8'h55, 2'b00, 16'd0, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 8'h00, 2'b10, 16'd0, 8'h00, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 8'hEE, 2'b10, 16'd0, 8'h00, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 8'h01, 2'b10, 16'd1, 8'h01, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 8'h02, 2'b10, 16'd2, 8'h02, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 8'hEE, 2'b10, 16'd2, 8'h02, 1'b1, 1'b1};

        #1 rst_n = 1'b0;
        #2 check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("ready_low_after_release", in_ready, 1'b0);

        // Run 1: first bytes from the table, then bubbly load, cpu_end held high, readback with a stall.
        for (int i = 0; i < 6; i++) begin
            in_valid = vecs[i].vld;
            in_data  = vecs[i].dat;
            @(negedge clk);
            check($sformatf("vec%0d", i), {cpu_status, cpu_addr, cpu_data, in_ready, busy},
                  {vecs[i].st, vecs[i].addr, vecs[i].wd, vecs[i].rdy, vecs[i].bsy});
            if (vecs[i].vld && cpu_status == 2'b10 && !seen[int'(cpu_addr)]) begin
                seen[int'(cpu_addr)] = 1'b1;
                n_seen++;
            end
        end
        ld_cnt = 3; m_rdy = 1'b1; m_st = 2'b10; m_addr = 16'd2; m_dat = 8'h02;
        cpu_end = 1'b1;
        run_load(1'b1, IN_N);
        check("distinct_addrs", n_seen, IN_N);

        in_valid = 1'b1;
        in_data  = 8'hC3;
        @(negedge clk);
        check("proc_first", {cpu_status, busy, in_ready, cpu_data}, {2'b01, 1'b1, 1'b0, 8'(IN_N - 1)});
        @(negedge clk);
        check("proc_end_ignored", {cpu_status, cpu_data}, {2'b01, 8'(IN_N - 1)});
        @(negedge clk);
        check("rd_issue1", {cpu_status, cpu_addr}, {2'b11, 16'd0});
        cpu_end = 1'b0;
        run_read(1'b1);

        // Run 2: continuous load abandoned by async reset, restarted, late cpu_end, full-rate readback.
        ld_cnt = 0; m_rdy = 1'b1; m_st = 2'b00; m_addr = 16'(OUT_N - 1); m_dat = 8'(IN_N - 1);
        run_load(1'b0, 301);
        check("addr_before_reset", cpu_addr, 16'd300);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("ready_low_after_rerelease", in_ready, 1'b0);
        ld_cnt = 0; m_rdy = 1'b0; m_st = 2'b00; m_addr = 16'd0; m_dat = 8'h00;
        run_load(1'b0, IN_N);

        repeat (500) @(negedge clk);
        check("proc_wait", {cpu_status, busy}, {2'b01, 1'b1});
        cpu_end = 1'b1;
        @(negedge clk);
        check("end_sampled", cpu_status, 2'b01);
        @(negedge clk);
        check("rd_issue2", {cpu_status, cpu_addr}, {2'b11, 16'd0});
        cpu_end = 1'b0;
        run_read(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
